// File: rtl/seg7_pkg.sv
// seg7_pkg: shared seven-segment decode table and segment bit positions.
//   SEG_A..SEG_G : bit index of each segment inside a 7-bit pattern (bit6..bit0 = g..a)
//   SEG_TABLE    : active-high pattern for each hex nibble, entry [n] = glyph n
package seg7_pkg;
   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;
   localparam logic [15:0][6:0] SEG_TABLE = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };
endpackage

// File: rtl/display7_scan_if.sv
// display7_scan_if: bus between a display client and the multiplexed scanner.
//   client -> scanner : Enable, Load, Data (4*NDIG), Dp (NDIG), Blank_lz
//   scanner -> client : Seg (7), DpOut, An (NDIG), Pending
interface display7_scan_if #(parameter int NDIG = 4);
   logic                Enable;
   logic                Load;
   logic [4*NDIG-1:0]   Data;
   logic [NDIG-1:0]     Dp;
   logic                Blank_lz;
   logic [6:0]          Seg;
   logic                DpOut;
   logic [NDIG-1:0]     An;
   logic                Pending;
   modport master (output Enable, Load, Data, Dp, Blank_lz, input Seg, DpOut, An, Pending);
   modport slave  (input Enable, Load, Data, Dp, Blank_lz, output Seg, DpOut, An, Pending);
endinterface

// File: rtl/seg7_decode.sv
// seg7_decode: combinational hex nibble to active-high segment pattern.
//   nib : 4-bit hex value
//   seg : 7-bit pattern, bit6..bit0 = g..a
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg
);
   assign seg = SEG_TABLE[nib];
endmodule

// File: rtl/display7_scan.sv
// display7_scan: time-multiplexed NDIG-digit seven-segment scanner with shadowed load.
//   Clk, Reset_n : clock and asynchronous active-low reset
//   bus (slave)  : Enable/Load/Data/Dp/Blank_lz in, Seg/DpOut/An/Pending out
module display7_scan #(
   parameter int NDIG       = 4,
   parameter int DIV        = 50000,
   parameter bit ACTIVE_LOW = 1
) (
   input logic           Clk,
   input logic           Reset_n,
   display7_scan_if.slave bus
);
   localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
   localparam int IW = NDIG > 1 ? $clog2(NDIG) : 1;

   if (NDIG < 1 || NDIG > 8 || DIV < 2) begin : g_bad_param
      $fatal(1, "display7_scan: illegal NDIG=%0d or DIV=%0d", NDIG, DIV);
   end

   logic [CW-1:0]        cnt;
   logic [IW-1:0]        idx;
   logic [NDIG-1:0][3:0] shd_d, dsp_d;
   logic [NDIG-1:0]      shd_p, dsp_p;
   logic                 pend;
   logic                 tick, wrap, lit, bl;
   logic [NDIG-1:0]      lz;
   logic [6:0]           dec;
   logic [6:0]           seg_q;
   logic                 dp_q;
   logic [NDIG-1:0]      an_q;

   assign tick = bus.Enable && cnt == CW'(DIV - 1);
   assign wrap = tick && idx == IW'(NDIG - 1);
   // the tick cycle is the dead slot between digits
   assign lit  = bus.Enable && !tick;

   seg7_decode u_dec (.nib(dsp_d[idx]), .seg(dec));

   // lz[k]: every digit from k up to NDIG-1 is zero
   always_comb begin
      lz = '0;
      lz[NDIG-1] = dsp_d[NDIG-1] == 4'h0;
      for (int k = NDIG - 2; k >= 0; k--) lz[k] = lz[k+1] && dsp_d[k] == 4'h0;
   end

   assign bl = bus.Blank_lz && idx != '0 && lz[idx];

   always_ff @(posedge Clk or negedge Reset_n)
      if (!Reset_n) begin
         cnt   <= '0;
         idx   <= '0;
         shd_d <= '0;
         shd_p <= '0;
         dsp_d <= '0;
         dsp_p <= '0;
         pend  <= 1'b0;
         seg_q <= '0;
         dp_q  <= 1'b0;
         an_q  <= '0;
      end else begin
         if (bus.Enable) cnt <= tick ? '0 : cnt + CW'(1);
         if (tick) idx <= wrap ? '0 : idx + IW'(1);
         if (wrap) begin
            dsp_d <= shd_d;
            dsp_p <= shd_p;
         end
         // commit reads the old shadow, so a coincident Load lands in the shadow and stays pending
         if (bus.Load) begin
            shd_d <= bus.Data;
            shd_p <= bus.Dp;
         end
         pend  <= bus.Load | (pend & ~wrap);
         an_q  <= lit ? NDIG'(1) << idx : '0;
         seg_q <= lit && !bl ? dec : '0;
         dp_q  <= lit && dsp_p[idx];
      end

   // registers hold the active-high form; polarity is applied at the pins
   assign bus.Seg     = seg_q ^ {7{ACTIVE_LOW}};
   assign bus.DpOut   = dp_q ^ ACTIVE_LOW;
   assign bus.An      = an_q ^ {NDIG{ACTIVE_LOW}};
   assign bus.Pending = pend;
endmodule

// File: tb/tb_display7_scan.sv
// tb_display7_scan: randomized and directed checks of display7_scan against a frame-time model.
module tb_display7_scan;
   localparam int NDIG = 4;
   localparam int DIV  = 4;

   logic Clk = 1'b0;
   logic Reset_n = 1'b1;

   display7_scan_if #(.NDIG(NDIG)) bus ();
   display7_scan #(.NDIG(NDIG), .DIV(DIV), .ACTIVE_LOW(1)) dut (.Clk(Clk), .Reset_n(Reset_n), .bus(bus));

   always #5 Clk = ~Clk;

   int checks = 0;
   int failures = 0;

   // model: m_t counts enabled cycles since reset; slot and phase follow from it arithmetically
   int          m_t;
   logic [15:0] m_shd, m_disp;
   logic [3:0]  m_shp, m_dsp;
   logic        m_pend;
   logic [6:0]  e_seg;
   logic        e_dp;
   logic [3:0]  e_an;
   logic [6:0]  tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_t = 0;
      m_shd = '0;
      m_disp = '0;
      m_shp = '0;
      m_dsp = '0;
      m_pend = 1'b0;
   endtask

   task automatic step(input bit en, input bit ld, input logic [15:0] d, input logic [3:0] dp, input bit blz);
      int slot, ph;
      bit commit;
      logic [15:0] hi;
      bus.Enable = en;
      bus.Load = ld;
      bus.Data = d;
      bus.Dp = dp;
      bus.Blank_lz = blz;
      @(posedge Clk);
      slot = (m_t / DIV) % NDIG;
      ph = m_t % DIV;
      if (en && ph != DIV - 1) begin
         hi = m_disp >> (4 * slot);
         e_an = ~(4'b0001 << slot);
         e_seg = (blz && slot > 0 && hi == 16'h0) ? 7'h7F : ~tbl[hi[3:0]];
         e_dp = ~m_dsp[slot];
      end else begin
         e_an = 4'hF;
         e_seg = 7'h7F;
         e_dp = 1'b1;
      end
      commit = en && ph == DIV - 1 && slot == NDIG - 1;
      if (commit) begin
         m_disp = m_shd;
         m_dsp = m_shp;
      end
      if (ld) begin
         m_shd = d;
         m_shp = dp;
         m_pend = 1'b1;
      end else if (commit) m_pend = 1'b0;
      if (en) m_t++;
      #1;
      check("an", 32'(bus.An), 32'(e_an));
      check("seg", 32'(bus.Seg), 32'(e_seg));
      check("dpout", 32'(bus.DpOut), 32'(e_dp));
      check("pending", 32'(bus.Pending), 32'(m_pend));
   endtask

   // reset is asserted between edges, so the checks see the asynchronous path
   task automatic do_reset();
      #2 Reset_n = 1'b0;
      #1;
      check("rst_an", 32'(bus.An), 32'h0000_000F);
      check("rst_seg", 32'(bus.Seg), 32'h0000_007F);
      check("rst_dp", 32'(bus.DpOut), 32'h1);
      check("rst_pend", 32'(bus.Pending), 32'h0);
      model_clear();
      @(posedge Clk);
      #2 Reset_n = 1'b1;
   endtask

   task automatic run(input int n, input bit blz);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'h0, 4'h0, blz);
   endtask

   initial begin
      bit hit, en, ld, blz;
      logic [15:0] d;
      bus.Enable = 1'b0;
      bus.Load = 1'b0;
      bus.Data = '0;
      bus.Dp = '0;
      bus.Blank_lz = 1'b0;
      model_clear();
      #1;
      do_reset();

      // plain load and two frames of scanning
      step(1'b1, 1'b1, 16'h1234, 4'b0101, 1'b0);
      run(40, 1'b0);

      // leading-zero blanking
      step(1'b1, 1'b1, 16'h0050, 4'b1000, 1'b1);
      run(36, 1'b1);
      step(1'b1, 1'b1, 16'h0000, 4'b0000, 1'b1);
      run(36, 1'b1);

      // Load coinciding with the commit tick
      step(1'b1, 1'b1, 16'hAAAA, 4'b0011, 1'b0);
      hit = 1'b0;
      for (int i = 0; i < 2 * NDIG * DIV && !hit; i++) begin
         if (m_t % (NDIG * DIV) == NDIG * DIV - 1) hit = 1'b1;
         else step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
      end
      check("commit_reached", 32'(hit), 32'h1);
      step(1'b1, 1'b1, 16'hBBBB, 4'b1100, 1'b0);
      run(18, 1'b0);

      // hold and blank, then resume
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
      run(34, 1'b0);

      // reset mid-frame while a load is pending
      step(1'b1, 1'b1, 16'h9876, 4'b1111, 1'b0);
      hit = 1'b0;
      for (int i = 0; i < 2 * NDIG * DIV && !hit; i++) begin
         if ((m_t / DIV) % NDIG == 2 && m_pend) hit = 1'b1;
         else step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
      end
      check("slot2_reached", 32'(hit), 32'h1);
      do_reset();
      run(36, 1'b0);

      // randomized traffic
      blz = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         if (i % 50 == 0) blz = 1'($urandom_range(0, 1));
         en = $urandom_range(0, 9) != 0;
         ld = $urandom_range(0, 7) == 0;
         d = 16'($urandom_range(0, 65535) >> (4 * $urandom_range(0, 4)));
         step(en, ld, d, 4'($urandom_range(0, 15)), blz);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/display7_scan.md
DISPLAY7_SCAN -- requirements
Module: display7_scan

Interface
REQ-001 The module SHALL have parameter NDIG, default 4, meaning number of digits (legal range 1..8).
REQ-002 The module SHALL have parameter DIV, default 50000, meaning clocks per digit slot (legal minimum 2).
REQ-003 The module SHALL have parameter ACTIVE_LOW, default 1, meaning Seg, DpOut and An are driven active-low when 1 and active-high when 0.
REQ-004 Port Clk  input  1  is the single clock; all state SHALL change on its rising edge.
REQ-005 Port Reset_n  input  1  is the reset; it SHALL be asynchronous and active-low.
REQ-006 Port Enable  input  1  SHALL select scanning when 1 and hold-and-blank when 0.
REQ-007 Port Load  input  1  SHALL act as a capture strobe for Data and Dp.
REQ-008 Port Data  input  4*NDIG  SHALL carry the hex nibbles; Data[3:0] is digit 0, the least significant digit.
REQ-009 Port Dp  input  NDIG  SHALL carry the decimal-point request per digit.
REQ-010 Port Blank_lz  input  1  SHALL enable leading-zero blanking.
REQ-011 Port Seg  output  7  SHALL drive the segments, bit6..bit0 = g..a.
REQ-012 Port DpOut  output  1  SHALL drive the decimal-point segment.
REQ-013 Port An  output  NDIG  SHALL drive the digit enables, An[k] = digit k.
REQ-014 Port Pending  output  1  SHALL indicate that a loaded value is not yet displayed.

Function
REQ-015 Prescaler SHALL count 0..DIV-1 while Enable=1, wrapping to 0; cycle with count DIV-1 SHALL be "tick".
REQ-016 Digit index SHALL advance on tick, modulo NDIG (NDIG-1 -> 0); frame period SHALL be exactly NDIG*DIV cycles.
REQ-017 Seg, DpOut and An SHALL be registered, reflecting the index of the previous cycle.
REQ-018 Each slot: An SHALL assert onehot(index) for DIV-1 cycles, then be all-inactive for 1 dead cycle, with Seg/DpOut inactive in that dead cycle.
REQ-019 Load=1 SHALL copy Data/Dp into a shadow register and set Pending; a later Load before commit SHALL overwrite the shadow.
REQ-020 Commit SHALL occur on the tick wrapping index NDIG-1 -> 0: display register <= shadow, Pending <= 0.
REQ-021 When Load coincides with commit, the old shadow SHALL be committed, the new value SHALL enter the shadow, and Pending SHALL remain 1.
REQ-022 Decode (active-high form) SHALL be: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-023 When Blank_lz=1, zero digits from digit NDIG-1 downward up to the first nonzero SHALL blank Seg (all inactive).
REQ-024 Digit 0 SHALL never be blanked by Blank_lz.
REQ-025 DpOut SHALL follow Dp of the displayed digit even when that digit is lz-blanked.
REQ-026 Enable=0 SHALL hold prescaler, index and Pending, and SHALL drive all outputs inactive (Load still captures).
REQ-027 On Enable returning to 1, scanning SHALL resume from the held count.
REQ-028 When ACTIVE_LOW=1, Seg, DpOut and An SHALL be the bitwise inverse of the active-high form.

Reset
REQ-029 Reset_n=0 SHALL asynchronously clear prescaler, index, shadow, display register and Pending to 0.
REQ-030 During reset, Seg, DpOut and An SHALL be inactive (all ones if ACTIVE_LOW=1).
REQ-031 Reset asserted mid-frame SHALL discard any pending load.

Structure
REQ-032 The 16-entry segment table and the segment bit-order constants SHALL live in shared package seg7_pkg.
REQ-033 Decode SHALL be a combinational sub-module seg7_decode (4-bit in, 7-bit active-high out); the block instantiates one.
REQ-034 Parameter legality SHALL be checked at elaboration; illegal values SHALL be a fatal error.

Verification (NDIG=4, DIV=4, ACTIVE_LOW=1)
REQ-035 Reset: Reset_n=0 asynchronously -> An=4'hF, Seg=7'h7F, DpOut=1, Pending=0, with no clock edge needed.
REQ-036 Load: Data=16'h1234 -> Pending=1 until frame wrap; next frame digit0 Seg=~7'h66 and digit3 Seg=~7'h06.
REQ-037 Blanking: Blank_lz=1 with Data=16'h0050 -> digits 3,2 Seg=7'h7F, digit1 Seg=~7'h6D, digit0 Seg=~7'h3F; Data=0 -> only digit0 lit (~7'h3F).
REQ-038 Timing: each An[k]=0 for 3 cycles followed by 1 cycle An=4'hF; frame period = 16 cycles.
REQ-039 Coincidence/hold: Load 16'hAAAA then 16'hBBBB on the commit cycle -> AAAA displayed and Pending=1; Enable=0 for 10 cycles -> An=4'hF, counts frozen, then resume.
REQ-040 Mid-frame reset: reset pulse during index 2 with Pending=1 -> index 0, Pending 0, blank display register.
